// File: rtl/snake_pkg.sv
// snake_pkg: shared constants and FSM state type for the snake datapath
//   COORD_W         coordinate/score width
//   OP_ADD, OP_SUB  add/subtract opcode values
//   serState        FSM states of the bit-serial add/subtract unit
package snake_pkg;
    localparam int COORD_W = 10;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} serState;
endpackage

// File: rtl/FULLADDER.sv
// FULLADDER: single-bit full adder used as the serial bit-slice
//   A, B  in   operand bits
//   Ci    in   carry in
//   Co    out  carry out
//   SUM   out  sum bit
module FULLADDER (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic Co,
    output logic SUM
);
    assign SUM = A ^ B ^ Ci;
    assign Co  = (A & B) | (Ci & (A ^ B));
endmodule

// File: rtl/serial_add_sub10.sv
// serial_add_sub10: bit-serial add/subtract, one bit per clock, LSB first
//   clk     in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   start   in   request, sampled only while idle
//   op      in   0 = a+b, 1 = a-b (captured with start)
//   a, b    in   operands (captured with start)
//   busy    out  operation in progress
//   done    out  one-cycle pulse when result is valid
//   result  out  sum/difference mod 2^WIDTH, held until the next done
//   cout    out  add: carry out; sub: 1 = no borrow
//   zero    out  result == 0
module serial_add_sub10
    import snake_pkg::*;
#(
    parameter int WIDTH = COORD_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    serState state;
    logic [WIDTH-1:0] aSr, bSr, resSr;
    logic [CNT_W-1:0] bitCnt;
    logic carry, faCo, faSum;

    FULLADDER uFa (.A(aSr[0]), .B(bSr[0]), .Ci(carry), .Co(faCo), .SUM(faSum));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            aSr    <= '0;
            bSr    <= '0;
            resSr  <= '0;
            bitCnt <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    aSr    <= a;
                    // subtraction runs as a + ~b + 1: invert b and seed the carry
                    bSr    <= b ^ {WIDTH{op}};
                    carry  <= (op == OP_SUB);
                    bitCnt <= '0;
                    busy   <= 1'b1;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    resSr  <= {faSum, resSr[WIDTH-1:1]};
                    carry  <= faCo;
                    aSr    <= aSr >> 1;
                    bSr    <= bSr >> 1;
                    bitCnt <= bitCnt + CNT_W'(1);
                    if (bitCnt == CNT_W'(WIDTH - 1)) state <= FIN;
                end
                FIN: begin
                    result <= resSr;
                    cout   <= carry;
                    zero   <= (resSr == '0);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
